uart_tx_arbiter: RTL and testbench

- Shares one uart_transmitter between two byte requesters (A, B) using round-robin arbitration.
- Owns the transmitter's control side: latches the granted byte and drives tx_data/tx_wr.
- Holds tx_wr until the transmitter acknowledges by raising Tx_BUSY, then waits for the frame to finish.
- Also registers the transmitter's enable and baud configuration so they only change between frames.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rr_arb2.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM encoding, baud codes and requester IDs.
// Other UART blocks import this package, so keep the encodings stable.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_t;

    localparam logic [2:0] BAUD_1200   = 3'b000;
    localparam logic [2:0] BAUD_2400   = 3'b001;
    localparam logic [2:0] BAUD_4800   = 3'b010;
    localparam logic [2:0] BAUD_9600   = 3'b011;
    localparam logic [2:0] BAUD_19200  = 3'b100;
    localparam logic [2:0] BAUD_38400  = 3'b101;
    localparam logic [2:0] BAUD_57600  = 3'b110;
    localparam logic [2:0] BAUD_115200 = 3'b111;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int WR_CNT_W = 16;

endpackage

// File: rtl/uart_rr_arb2.sv
// Combinational two-way round-robin select: a lone request always wins,
// a tie goes to the requester that did not own the last frame.
module uart_rr_arb2
    import uart_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid = req_a | req_b;
        if (req_a && req_b) begin
            winner = ~last_grant;
        end else if (req_b) begin
            winner = REQ_B;
        end else begin
            winner = REQ_A;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between requesters A and B: latches the granted
// byte, drives tx_wr until tx_busy acknowledges, then waits out the frame.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned WR_TIMEOUT = 65535,
    parameter logic [2:0]  RESET_BAUD = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] baud_cfg,
    input  logic       req_a,
    input  logic [7:0] data_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [7:0] data_b,
    output logic       ack_b,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    output logic       tx_en,
    output logic [2:0] baud_select,
    input  logic       tx_busy,
    output logic       grant_id,
    output logic       timeout_err,
    output arb_state_t fsm_state
);

    // Handshakes: req_x/data_x act as valid+payload and must hold until ack_x,
    // a one-cycle capture strobe given only when req_x is high in the grant
    // cycle. tx_wr acts as valid toward the transmitter and drops once tx_busy
    // rises (accepted) or after WR_TIMEOUT cycles (byte dropped, sticky error).
    // WR_TIMEOUT must lie in 1..65535 to fit the 16-bit wait counter.
    localparam logic [WR_CNT_W-1:0] WR_LAST = WR_CNT_W'(WR_TIMEOUT - 1);

    arb_state_t          state_q;
    arb_state_t          state_d;
    logic [WR_CNT_W-1:0] wr_cnt;
    logic                arb_valid;
    logic                arb_winner;
    logic                grant;
    logic                wr_expired;

    uart_rr_arb2 u_rr_arb2 (
        .req_a      (req_a),
        .req_b      (req_b),
        .last_grant (grant_id),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    assign grant      = (state_q == ST_IDLE) && enable && !tx_busy && arb_valid;
    assign wr_expired = (wr_cnt == WR_LAST);
    assign fsm_state  = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A tx_busy rise in the same cycle as expiry counts as acceptance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (wr_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data     <= 8'h00;
            tx_wr       <= 1'b0;
            tx_en       <= 1'b0;
            baud_select <= RESET_BAUD;
            ack_a       <= 1'b0;
            ack_b       <= 1'b0;
            grant_id    <= REQ_B;
            timeout_err <= 1'b0;
            wr_cnt      <= '0;
        end else begin
            tx_en <= enable;
            ack_a <= grant && (arb_winner == REQ_A);
            ack_b <= grant && (arb_winner == REQ_B);
            // Baud only moves between frames so a byte never straddles two rates.
            if ((state_q == ST_IDLE) && !tx_busy) begin
                baud_select <= baud_cfg;
            end
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        tx_data  <= (arb_winner == REQ_B) ? data_b : data_a;
                        grant_id <= arb_winner;
                        tx_wr    <= 1'b1;
                        wr_cnt   <= '0;
                    end
                end
                ST_WRITE: begin
                    if (tx_busy) begin
                        tx_wr <= 1'b0;
                    end else if (wr_expired) begin
                        tx_wr       <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural transmitter + serial receiver,
// table of request batches, and hand sequences for multi-cycle corners.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int BIT_CYC = 8;
    localparam int TMO     = 100;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [2:0] baud_cfg;
    logic       req_a;
    logic [7:0] data_a;
    logic       ack_a;
    logic       req_b;
    logic [7:0] data_b;
    logic       ack_b;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_en;
    logic [2:0] baud_select;
    logic       tx_busy;
    logic       grant_id;
    logic       timeout_err;
    arb_state_t fsm_state;

    logic       auto_busy;
    logic       man_busy;
    logic       model_on;
    logic       txd;

    int n_checks;
    int n_pass;
    int since_fall;
    logic prev_busy;
    logic prev_ack_a;
    logic prev_ack_b;

    logic [8:0] exp_q[$];
    logic [7:0] frame_q[$];

    assign tx_busy = model_on ? auto_busy : man_busy;

    uart_tx_arbiter #(.WR_TIMEOUT(TMO), .RESET_BAUD(3'b111)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .baud_cfg    (baud_cfg),
        .req_a       (req_a),
        .data_a      (data_a),
        .ack_a       (ack_a),
        .req_b       (req_b),
        .data_b      (data_b),
        .ack_b       (ack_b),
        .tx_data     (tx_data),
        .tx_wr       (tx_wr),
        .tx_en       (tx_en),
        .baud_select (baud_select),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- transmitter model ----------------
    initial begin
        logic [7:0] b;
        auto_busy = 1'b0;
        txd = 1'b1;
        forever begin
            @(negedge clk);
            if (model_on && tx_wr && !auto_busy) begin
                repeat (2) @(negedge clk);
                b = tx_data;
                auto_busy = 1'b1;
                txd = 1'b0;
                repeat (BIT_CYC) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    txd = b[i];
                    repeat (BIT_CYC) @(negedge clk);
                end
                txd = 1'b1;
                repeat (BIT_CYC) @(negedge clk);
                auto_busy = 1'b0;
            end
        end
    end

    // ---------------- serial receiver / frame scoreboard ----------------
    initial begin
        logic [7:0] rx;
        rx = 8'h00;
        forever begin
            @(posedge clk);
            if (txd == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat ((i == 0) ? BIT_CYC + BIT_CYC / 2 : BIT_CYC) @(posedge clk);
                    rx[i] = txd;
                end
                repeat (BIT_CYC) @(posedge clk);
                check("stop_bit", 32'(txd), 32'd1);
                if (frame_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_frame: got 0x%0h, want none at %0t", rx, $time);
                end else begin
                    check("rx_byte", 32'(rx), 32'(frame_q.pop_front()));
                end
            end
        end
    end

    // cycles since tx_busy last fell, sampled on the active edge
    always @(posedge clk) begin
        if (prev_busy && !tx_busy) since_fall = 1;
        else since_fall = since_fall + 1;
        prev_busy = tx_busy;
    end

    // ---------------- ack scoreboard ----------------
    always @(negedge clk) begin
        logic [8:0] e;
        if (ack_a || ack_b) begin
            check("ack_exclusive", 32'(ack_a & ack_b), 32'd0);
            if (ack_a) check("ack_a_width", 32'(prev_ack_a), 32'd0);
            if (ack_b) check("ack_b_width", 32'(prev_ack_b), 32'd0);
            check("tx_wr_at_ack", 32'(tx_wr), 32'd1);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ack: got a=%0b b=%0b, want none at %0t", ack_a, ack_b, $time);
            end else begin
                e = exp_q.pop_front();
                check("ack_owner", 32'(ack_b), 32'(e[8]));
                check("grant_id", 32'(grant_id), 32'(e[8]));
                check("tx_data", 32'(tx_data), 32'(e[7:0]));
            end
        end
        prev_ack_a = ack_a;
        prev_ack_b = ack_b;
    end

    // ---------------- driver tasks ----------------
    task automatic expect_byte(input logic id, input logic [7:0] d, input logic framed);
        exp_q.push_back({id, d});
        if (framed) frame_q.push_back(d);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 3000;
        do begin
            @(posedge clk);
            budget--;
        end while (!(fsm_state == ST_IDLE && !tx_busy && !tx_wr) && budget > 0);
        check("idle_reached", 32'(budget > 0), 32'd1);
        @(negedge clk);
    endtask

    task automatic run_batch(input logic ua, input logic ub, input logic [7:0] da,
                             input logic [7:0] db, input logic first_b);
        logic pend_a;
        logic pend_b;
        int   budget;
        if (ua && ub) begin
            expect_byte(first_b, first_b ? db : da, 1'b1);
            expect_byte(~first_b, first_b ? da : db, 1'b1);
        end else if (ua) begin
            expect_byte(REQ_A, da, 1'b1);
        end else if (ub) begin
            expect_byte(REQ_B, db, 1'b1);
        end
        @(negedge clk);
        req_a = ua; data_a = da; req_b = ub; data_b = db;
        pend_a = ua; pend_b = ub;
        budget = 2000;
        if (!ua && !ub) begin
            repeat (6) begin
                @(negedge clk);
                check("no_req_no_ack", 32'(ack_a | ack_b), 32'd0);
            end
        end
        while ((pend_a || pend_b) && budget > 0) begin
            @(negedge clk);
            budget--;
            if (ack_a) begin req_a = 1'b0; pend_a = 1'b0; end
            if (ack_b) begin req_b = 1'b0; pend_b = 1'b0; end
        end
        check("batch_served", 32'(pend_a | pend_b), 32'd0);
        req_a = 1'b0; req_b = 1'b0;
        wait_idle();
    endtask

    task automatic wait_ack(output logic got);
        int budget;
        budget = 500;
        got = 1'b0;
        while (!got && budget > 0) begin
            @(negedge clk);
            budget--;
            got = ack_a | ack_b;
        end
        check("ack_seen", 32'(got), 32'd1);
    endtask

    typedef struct {
        logic       ua;
        logic       ub;
        logic [7:0] da;
        logic [7:0] db;
        logic       first_b;
        logic       last_id;
    } vec_t;

    vec_t vecs[8];

    // ---------------- main sequence ----------------
    initial begin
        logic got;
        int   n_acks;
        int   cnt;
        n_checks = 0; n_pass = 0; since_fall = 0;
        prev_busy = 1'b0; prev_ack_a = 1'b0; prev_ack_b = 1'b0;
        model_on = 1'b1; man_busy = 1'b0;
        reset = 1'b1; enable = 1'b1; baud_cfg = 3'b010;
        req_a = 1'b0; req_b = 1'b0; data_a = 8'h00; data_b = 8'h00;

        vecs[0] = '{1'b1, 1'b0, 8'hAA, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'hBB, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 8'h55, 8'hCC, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 8'h77, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 8'h9A, 8'hBC, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'hDE, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 8'h01, 8'h02, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 8'h33, 8'h44, 1'b0, 1'b1};

        // reset held for 1 us
        repeat (100) @(negedge clk);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_tx_wr", 32'(tx_wr), 32'd0);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_baud", 32'(baud_select), 32'h7);
        check("rst_acks", 32'({ack_a, ack_b}), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd1);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        baud_cfg = 3'b111;
        reset = 1'b0;
        @(negedge clk);
        check("tx_en_follows", 32'(tx_en), 32'd1);

        // table of request batches
        for (int i = 0; i < 8; i++) begin
            run_batch(vecs[i].ua, vecs[i].ub, vecs[i].da, vecs[i].db, vecs[i].first_b);
            check("grant_id_after_batch", 32'(grant_id), 32'(vecs[i].last_id));
        end

        // both held: A,B,A,B then A; next grant 2 edges after tx_busy falls
        for (int k = 0; k < 5; k++) expect_byte(k[0], k[0] ? 8'hCC : 8'h55, 1'b1);
        req_a = 1'b1; data_a = 8'h55; req_b = 1'b1; data_b = 8'hCC;
        n_acks = 0; cnt = 4000;
        while (n_acks < 5 && cnt > 0) begin
            @(negedge clk);
            cnt--;
            if (ack_a || ack_b) begin
                n_acks++;
                if (n_acks > 1) check("regrant_gap", 32'(since_fall), 32'd2);
                if (n_acks == 4) req_b = 1'b0;
                if (n_acks == 5) req_a = 1'b0;
            end
        end
        check("rr_acks", 32'(n_acks), 32'd5);
        req_a = 1'b0; req_b = 1'b0;
        wait_idle();

        // single requester back-to-back, new byte each ack
        for (int k = 0; k < 3; k++) expect_byte(REQ_B, 8'h10 + 8'(k), 1'b1);
        req_b = 1'b1; data_b = 8'h10;
        n_acks = 0; cnt = 3000;
        while (n_acks < 3 && cnt > 0) begin
            @(negedge clk);
            cnt--;
            if (ack_b) begin
                n_acks++;
                if (n_acks > 1) check("b2b_gap", 32'(since_fall), 32'd2);
                data_b = data_b + 8'd1;
                if (n_acks == 3) req_b = 1'b0;
            end
        end
        check("b2b_acks", 32'(n_acks), 32'd3);
        wait_idle();

        // enable dropped in WAIT_DONE with req_b pending
        expect_byte(REQ_A, 8'h96, 1'b1);
        req_a = 1'b1; data_a = 8'h96;
        wait_ack(got);
        req_a = 1'b0;
        cnt = 200;
        do begin @(posedge clk); cnt--; end while (!tx_busy && cnt > 0);
        @(negedge clk);
        enable = 1'b0; req_b = 1'b1; data_b = 8'h69;
        @(negedge clk);
        check("tx_en_low", 32'(tx_en), 32'd0);
        cnt = 200;
        do begin @(posedge clk); cnt--; end while (tx_busy && cnt > 0);
        repeat (10) begin
            @(negedge clk);
            check("no_grant_disabled", 32'(ack_b), 32'd0);
        end
        check("idle_disabled", 32'(fsm_state), 32'(ST_IDLE));
        expect_byte(REQ_B, 8'h69, 1'b1);
        enable = 1'b1;
        @(negedge clk);
        check("grant_on_enable", 32'(ack_b), 32'd1);
        req_b = 1'b0;
        wait_idle();

        // baud change mid-frame
        expect_byte(REQ_A, 8'h81, 1'b1);
        req_a = 1'b1; data_a = 8'h81;
        wait_ack(got);
        req_a = 1'b0;
        cnt = 200;
        do begin @(posedge clk); cnt--; end while (!tx_busy && cnt > 0);
        @(negedge clk);
        baud_cfg = 3'b000;
        repeat (4) begin
            repeat (10) @(negedge clk);
            check("baud_hold", 32'(baud_select), 32'h7);
        end
        cnt = 200;
        do begin @(posedge clk); cnt--; end while (tx_busy && cnt > 0);
        repeat (2) @(negedge clk);
        check("baud_apply", 32'(baud_select), 32'h0);
        wait_idle();

        // timeout: transmitter never answers
        model_on = 1'b0;
        expect_byte(REQ_A, 8'h5A, 1'b0);
        req_a = 1'b1; data_a = 8'h5A;
        wait_ack(got);
        req_a = 1'b0;
        cnt = 1;
        for (int k = 0; k < 300 && tx_wr; k++) begin
            @(negedge clk);
            if (tx_wr) cnt++;
        end
        check("tx_wr_high_cycles", 32'(cnt), 32'(TMO));
        check("timeout_set", 32'(timeout_err), 32'd1);
        check("timeout_idle", 32'(fsm_state), 32'(ST_IDLE));

        // tx_busy already high in IDLE: no grant
        man_busy = 1'b1; req_b = 1'b1; data_b = 8'hB7;
        repeat (8) begin
            @(negedge clk);
            check("busy_blocks_grant", 32'(ack_b), 32'd0);
        end
        check("timeout_sticky", 32'(timeout_err), 32'd1);
        expect_byte(REQ_B, 8'hB7, 1'b0);
        man_busy = 1'b0;
        @(negedge clk);
        check("grant_after_busy", 32'(ack_b), 32'd1);
        req_b = 1'b0; man_busy = 1'b1;
        @(negedge clk);
        check("wr_drops_on_busy", 32'(tx_wr), 32'd0);
        check("wait_done_state", 32'(fsm_state), 32'(ST_WAIT_DONE));
        man_busy = 1'b0;
        wait_idle();

        // reset while in WRITE, next byte from A still pending
        expect_byte(REQ_A, 8'h3C, 1'b0);
        req_a = 1'b1; data_a = 8'h3C;
        wait_ack(got);
        baud_cfg = 3'b101;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_tx_wr", 32'(tx_wr), 32'd0);
        check("arst_tx_data", 32'(tx_data), 32'h00);
        check("arst_tx_en", 32'(tx_en), 32'd0);
        check("arst_baud", 32'(baud_select), 32'h7);
        check("arst_grant_id", 32'(grant_id), 32'd1);
        check("arst_timeout_err", 32'(timeout_err), 32'd0);
        check("arst_state", 32'(fsm_state), 32'(ST_IDLE));
        repeat (3) begin
            @(negedge clk);
            check("arst_no_ack", 32'(ack_a | ack_b), 32'd0);
        end
        expect_byte(REQ_A, 8'h3C, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("regrant_after_reset", 32'(ack_a), 32'd1);
        req_a = 1'b0;

        // tx_busy rises in the same cycle the write would expire
        repeat (TMO - 1) @(negedge clk);
        man_busy = 1'b1;
        @(negedge clk);
        check("tie_wr_low", 32'(tx_wr), 32'd0);
        check("tie_state", 32'(fsm_state), 32'(ST_WAIT_DONE));
        check("tie_no_error", 32'(timeout_err), 32'd0);
        man_busy = 1'b0;
        wait_idle();
        check("baud_after_reset", 32'(baud_select), 32'h5);

        check("acks_drained", 32'(exp_q.size()), 32'd0);
        check("frames_drained", 32'(frame_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
